adc_dma_writer: RTL and testbench

//  Bus initiator (DMA) on the FemtoRV32-style memory bus: packs 8-bit ADC samples into 32-bit words
//  and writes them to consecutive RAM words without CPU involvement.

---
 rtl/adc_dma_writer.sv | 172 +++++++++++++++++
 tb/tb_adc_dma_writer.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dma_writer.sv
// adc_dma_writer: DMA initiator that packs 8-bit ADC samples little-endian into 32-bit words
// and writes them to consecutive RAM words on the FemtoRV32-style memory bus.
module adc_dma_writer #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic             sample_valid,
  input  logic [7:0]       sample_data,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wmask,
  output logic             mem_rstrb,
  input  logic             mem_wbusy,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [LEN_W-1:0] words_written
);

  typedef enum logic [1:0] {StIdle, StRun, StWrite, StDone} state_e;

  state_e           state_q, state_d;
  logic [29:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] ww_q, ww_d;
  logic [LEN_W-1:0] handed_q, handed_d;   // words moved from packer to pending register
  logic             overrun_q, overrun_d;
  logic [31:0]      pack_q, pack_d;
  logic [2:0]       byte_cnt_q, byte_cnt_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_word_q, pend_word_d;

  logic             packing;
  logic             write_done;
  logic             slot_free;
  logic             sample_ok;
  logic [LEN_W-1:0] ww_inc;
  logic [29:0]      word_addr;

  // Address alignment bits are deliberately ignored.
  logic             unused_base_lsb;
  assign unused_base_lsb = ^base_addr[1:0];

  assign packing    = (state_q == StRun) || (state_q == StWrite);
  assign write_done = (state_q == StWrite) && !mem_wbusy;
  // Pending register can accept a word this edge if it is empty or being drained.
  assign slot_free  = !pend_q || write_done;
  // Samples beyond the requested word count are silently ignored.
  assign sample_ok  = packing && sample_valid && (handed_q != len_q);
  assign ww_inc     = ww_q + LEN_W'(1);
  // Word-granular add gives byte address wrap modulo 2^32.
  assign word_addr  = base_q + 30'(ww_q);

  // Next-state: transfer FSM, write completion, and sample packer.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    ww_d        = ww_q;
    handed_d    = handed_q;
    overrun_d   = overrun_q;
    pack_d      = pack_q;
    byte_cnt_d  = byte_cnt_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ww_d       = '0;
          handed_d   = '0;
          overrun_d  = 1'b0;
          byte_cnt_d = '0;
          pend_d     = 1'b0;
          if (len_words != '0) begin
            base_d  = base_addr[31:2];
            len_d   = len_words;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (pend_q) state_d = StWrite;
      end
      StWrite: begin
        if (!mem_wbusy) begin
          ww_d    = ww_inc;
          pend_d  = 1'b0;
          state_d = (ww_inc == len_q) ? StDone : StRun;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (packing) begin
      // A full packer drains as soon as the pending register frees up.
      if (byte_cnt_q == 3'd4 && slot_free) begin
        pend_word_d = pack_q;
        pend_d      = 1'b1;
        byte_cnt_d  = '0;
        handed_d    = handed_q + LEN_W'(1);
      end
      if (sample_ok) begin
        if (byte_cnt_q == 3'd4) begin
          overrun_d = 1'b1;
        end else if (byte_cnt_q == 3'd3 && slot_free) begin
          pend_word_d = {sample_data, pack_q[23:0]};
          pend_d      = 1'b1;
          byte_cnt_d  = '0;
          handed_d    = handed_q + LEN_W'(1);
        end else begin
          pack_d[{byte_cnt_q[1:0], 3'b000} +: 8] = sample_data;
          byte_cnt_d = byte_cnt_q + 3'd1;
        end
      end
    end
  end

  // State registers; reset empties the packer and abandons any write in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      ww_q        <= '0;
      handed_q    <= '0;
      overrun_q   <= 1'b0;
      pack_q      <= '0;
      byte_cnt_q  <= '0;
      pend_q      <= 1'b0;
      pend_word_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      ww_q        <= ww_d;
      handed_q    <= handed_d;
      overrun_q   <= overrun_d;
      pack_q      <= pack_d;
      byte_cnt_q  <= byte_cnt_d;
      pend_q      <= pend_d;
      pend_word_q <= pend_word_d;
    end
  end

  // Bus and status outputs decoded from state so reset clears them immediately.
  always_comb begin
    mem_wmask     = 4'h0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (state_q == StWrite) begin
      mem_wmask = 4'hF;
      mem_addr  = {word_addr, 2'b00};
      mem_wdata = pend_word_q;
    end
    mem_rstrb     = 1'b0;
    busy          = packing;
    done          = (state_q == StDone);
    overrun       = overrun_q;
    words_written = ww_q;
  end

endmodule

// File: tb/tb_adc_dma_writer.sv
// Self-checking bench for adc_dma_writer with a queue-based reference model.
module tb_adc_dma_writer;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [31:0]      base_addr;
  logic [LEN_W-1:0] len_words;
  logic             sample_valid;
  logic [7:0]       sample_data;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wmask;
  logic             mem_rstrb;
  logic             mem_wbusy;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [LEN_W-1:0] words_written;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wr_q[$];
  int          done_cnt  = 0;
  int          wmask_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        prev_done  = 1'b0;
  logic [31:0] prev_addr, prev_data;
  bit          rand_busy = 1'b0;
  int          busy_run  = 0;

  adc_dma_writer #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .base_addr    (base_addr),
    .len_words    (len_words),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rstrb    (mem_rstrb),
    .mem_wbusy    (mem_wbusy),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Bus monitor on the falling edge: records completed writes, checks stall hold and done pulse.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      checks++;
      if (mem_rstrb !== 1'b0 || (mem_wmask !== 4'h0 && mem_wmask !== 4'hF) ||
          (mem_wmask === 4'h0 && (mem_addr !== 32'h0 || mem_wdata !== 32'h0))) begin
        errors++;
        $display("FAIL bus_quiet: rstrb=%b wmask=%h addr=%h wdata=%h, required rstrb=0, wmask 0/F, addr=wdata=0 when idle",
                 mem_rstrb, mem_wmask, mem_addr, mem_wdata);
      end
      if (prev_stall) begin
        checks++;
        if (mem_wmask !== 4'hF || mem_addr !== prev_addr || mem_wdata !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: wmask=%h addr=%h wdata=%h, required F %h %h",
                   mem_wmask, mem_addr, mem_wdata, prev_addr, prev_data);
        end
      end
      if (mem_wmask === 4'hF) begin
        wmask_cnt++;
        if (mem_wbusy === 1'b0) wr_q.push_back({mem_addr, mem_wdata});
      end
      prev_stall = (mem_wmask === 4'hF) && (mem_wbusy === 1'b1);
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
      if (done === 1'b1) begin
        done_cnt++;
        checks++;
        if (prev_done || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: prev_done=%b busy=%b, required 0 0", prev_done, busy);
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  // Global watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_busy) begin
      if (busy_run >= 3 || $urandom_range(0, 2) != 0) begin
        mem_wbusy = 1'b0;
        busy_run  = 0;
      end else begin
        mem_wbusy = 1'b1;
        busy_run++;
      end
    end
  endtask

  task automatic send_sample(input logic [7:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [LEN_W-1:0] l);
    base_addr = b;
    len_words = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Waits (bounded) until done_cnt moves past d0; callers check the count afterwards.
  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    tick();
  endtask

  task automatic wait_wmask(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (mem_wmask === 4'hF) break;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; base_addr = '0; len_words = '0;
    sample_valid = 1'b0; sample_data = '0; mem_wbusy = 1'b0;
    tick();
    checks++;
    if (mem_wmask !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 ||
        words_written !== '0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_idle: wmask=%h busy=%b done=%b ovr=%b ww=%0d addr=%h, required all 0",
               mem_wmask, busy, done, overrun, words_written, mem_addr);
    end
    tick();
    resetn = 1'b1;
    tick();
    // Reset in the middle of a stalled second write.
    pulse_start(32'h0000_2000, 2);
    for (int i = 0; i < 4; i++) send_sample(8'(8'hA0 + i));
    for (int i = 0; i < 20; i++) begin
      if (wr_q.size() != 0) break;
      @(negedge clk);
      #1;
    end
    tick();
    mem_wbusy = 1'b1;
    for (int i = 0; i < 4; i++) send_sample(8'(8'hB0 + i));
    wait_wmask(10);
    checks++;
    if (mem_wmask !== 4'hF || words_written !== 16'd1) begin
      errors++;
      $display("FAIL reset_prewrite: wmask=%h ww=%0d, required F 1", mem_wmask, words_written);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (mem_wmask !== 4'h0 || mem_addr !== 32'h0 || busy !== 1'b0 || done !== 1'b0 ||
        overrun !== 1'b0 || words_written !== '0) begin
      errors++;
      $display("FAIL reset_midwrite: wmask=%h addr=%h busy=%b done=%b ovr=%b ww=%0d, required all 0",
               mem_wmask, mem_addr, busy, done, overrun, words_written);
    end
    @(negedge clk);
    tick();
    resetn    = 1'b1;
    mem_wbusy = 1'b0;
    checks++;
    if (wr_q.size() != 1) begin
      errors++;
      $display("FAIL reset_writes: got %0d completed writes, required 1", wr_q.size());
    end
    wr_q.delete();
    tick();
  endtask

  task automatic test_basic();
    int d0;
    int lat;
    d0 = done_cnt;
    wr_q.delete();
    pulse_start(32'h0000_1000, 2);
    for (int i = 1; i <= 3; i++) send_sample(8'(i));
    sample_valid = 1'b1;
    sample_data  = 8'h04;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sample_valid = 1'b0;
      lat++;
      @(negedge clk);
      #1;
      if (mem_wmask === 4'hF) break;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL basic_latency: wmask after %0d cycles, required 2", lat);
    end
    tick();
    for (int i = 5; i <= 8; i++) send_sample(8'(i));
    wait_done(d0, 20);
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== {32'h0000_1000, 32'h0403_0201} ||
        wr_q[1] !== {32'h0000_1004, 32'h0807_0605}) begin
      errors++;
      $display("FAIL basic_writes: n=%0d w0=%h w1=%h, required 2 0000100004030201 0000100408070605",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, (wr_q.size() > 1) ? wr_q[1] : 64'h0);
    end
    checks++;
    if (done_cnt != d0 + 1 || words_written !== 16'd2 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done=%0d ww=%0d busy=%b ovr=%b, required %0d 2 0 0",
               done_cnt - d0, words_written, busy, overrun, 1);
    end
  endtask

  task automatic test_stall();
    int d0;
    logic [7:0] b[4];
    logic [31:0] a0, w0;
    d0 = done_cnt;
    wr_q.delete();
    mem_wbusy = 1'b1;
    pulse_start(32'h0000_3000, 1);
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      send_sample(b[i]);
    end
    wait_wmask(10);
    a0 = mem_addr;
    w0 = mem_wdata;
    checks++;
    if (mem_wmask !== 4'hF || a0 !== 32'h0000_3000 || w0 !== {b[3], b[2], b[1], b[0]}) begin
      errors++;
      $display("FAIL stall_first: wmask=%h addr=%h data=%h, required F 00003000 %h",
               mem_wmask, a0, w0, {b[3], b[2], b[1], b[0]});
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 5) mem_wbusy = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (mem_wmask !== 4'hF || mem_addr !== a0 || mem_wdata !== w0) begin
        errors++;
        $display("FAIL stall_cycle%0d: wmask=%h addr=%h data=%h, required F %h %h",
                 i + 1, mem_wmask, mem_addr, mem_wdata, a0, w0);
      end
    end
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (mem_wmask !== 4'h0) begin
      errors++;
      $display("FAIL stall_release: wmask=%h, required 0", mem_wmask);
    end
    wait_done(d0, 10);
    checks++;
    if (wr_q.size() != 1 || words_written !== 16'd1 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL stall_count: writes=%0d ww=%0d done=%0d, required 1 1 1",
               wr_q.size(), words_written, done_cnt - d0);
    end
  endtask

  task automatic test_overrun();
    int d0;
    d0 = done_cnt;
    wr_q.delete();
    mem_wbusy = 1'b1;
    pulse_start(32'h0000_4000, 2);
    for (int i = 0; i < 9; i++) send_sample(8'(8'h11 + i));
    tick();
    checks++;
    if (overrun !== 1'b1 || words_written !== 16'd0) begin
      errors++;
      $display("FAIL overrun_flag: ovr=%b ww=%0d, required 1 0", overrun, words_written);
    end
    mem_wbusy = 1'b0;
    wait_done(d0, 20);
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== {32'h0000_4000, 32'h1413_1211} ||
        wr_q[1] !== {32'h0000_4004, 32'h1817_1615}) begin
      errors++;
      $display("FAIL overrun_writes: n=%0d w0=%h w1=%h, required 2 0000400014131211 0000400418171615",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, (wr_q.size() > 1) ? wr_q[1] : 64'h0);
    end
    checks++;
    if (overrun !== 1'b1 || words_written !== 16'd2 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL overrun_sticky: ovr=%b ww=%0d done=%0d, required 1 2 1",
               overrun, words_written, done_cnt - d0);
    end
  endtask

  task automatic test_len0_wrap();
    int d0;
    int wm0;
    int lat;
    logic [7:0] b[8];
    d0  = done_cnt;
    wm0 = wmask_cnt;
    pulse_start(32'h0000_5000, 0);
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (done_cnt != d0) break;
    end
    checks++;
    if (done_cnt != d0 + 1 || lat > 2) begin
      errors++;
      $display("FAIL len0_done: done=%0d after %0d cycles, required 1 within 2", done_cnt - d0, lat);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (wmask_cnt != wm0 || busy !== 1'b0 || overrun !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL len0_quiet: wmask_cycles=%0d busy=%b ovr=%b done=%0d, required 0 0 0 1",
               wmask_cnt - wm0, busy, overrun, done_cnt - d0);
    end
    d0 = done_cnt;
    wr_q.delete();
    pulse_start(32'hFFFF_FFFC, 2);
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'($urandom);
      send_sample(b[i]);
    end
    wait_done(d0, 20);
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== {32'hFFFF_FFFC, b[3], b[2], b[1], b[0]} ||
        wr_q[1] !== {32'h0000_0000, b[7], b[6], b[5], b[4]}) begin
      errors++;
      $display("FAIL wrap_writes: n=%0d w0=%h w1=%h, required FFFFFFFC%h 00000000%h", wr_q.size(),
               (wr_q.size() > 0) ? wr_q[0] : 64'h0, (wr_q.size() > 1) ? wr_q[1] : 64'h0,
               {b[3], b[2], b[1], b[0]}, {b[7], b[6], b[5], b[4]});
    end
  endtask

  task automatic test_start_busy();
    int d0;
    logic [7:0] b[4];
    d0 = done_cnt;
    wr_q.delete();
    pulse_start(32'h0000_1003, 1);
    for (int i = 0; i < 2; i++) begin
      b[i] = 8'($urandom);
      send_sample(b[i]);
    end
    pulse_start(32'h0000_2000, 5);
    for (int i = 2; i < 4; i++) begin
      b[i] = 8'($urandom);
      send_sample(b[i]);
    end
    wait_done(d0, 20);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {32'h0000_1000, b[3], b[2], b[1], b[0]}) begin
      errors++;
      $display("FAIL busy_start_writes: n=%0d w0=%h, required 1 00001000%h", wr_q.size(),
               (wr_q.size() > 0) ? wr_q[0] : 64'h0, {b[3], b[2], b[1], b[0]});
    end
    checks++;
    if (words_written !== 16'd1 || done_cnt != d0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_status: ww=%0d done=%0d busy=%b, required 1 1 0",
               words_written, done_cnt - d0, busy);
    end
  endtask

  task automatic test_random();
    int          d0;
    int          len;
    int          extra;
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [7:0]  bytes[$];
    for (int it = 0; it < 20; it++) begin
      d0    = done_cnt;
      base  = $urandom;
      len   = $urandom_range(1, 5);
      extra = $urandom_range(0, 3);
      bytes.delete();
      wr_q.delete();
      rand_busy = 1'b1;
      pulse_start(base, LEN_W'(len));
      for (int i = 0; i < 4 * len + extra; i++) begin
        bytes.push_back(8'($urandom));
        send_sample(bytes[i]);
        for (int g = 0; g < $urandom_range(3, 5); g++) tick();
      end
      wait_done(d0, 60);
      rand_busy = 1'b0;
      mem_wbusy = 1'b0;
      tick();
      checks++;
      if (done_cnt != d0 + 1 || wr_q.size() != len || words_written !== LEN_W'(len) ||
          overrun !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_status: done=%0d writes=%0d ww=%0d ovr=%b, required 1 %0d %0d 0",
                 it, done_cnt - d0, wr_q.size(), words_written, overrun, len, len);
      end
      for (int w = 0; w < len && w < wr_q.size(); w++) begin
        exp_addr = {base[31:2], 2'b00} + 32'(4 * w);
        exp_data = {bytes[4 * w + 3], bytes[4 * w + 2], bytes[4 * w + 1], bytes[4 * w]};
        checks++;
        if (wr_q[w] !== {exp_addr, exp_data}) begin
          errors++;
          $display("FAIL rand%0d_word%0d: got %h, required %h%h", it, w, wr_q[w], exp_addr, exp_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_len0_wrap();
    test_start_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
